// File: rtl/team_05_gpio_arbiter.sv
// Round-robin arbiter handing a shared GPIO pad bank to one of NREQ requesters,
// with hold-time preemption and a turnaround guard between owners.
module team_05_gpio_arbiter #(
    parameter int NREQ      = 4,
    parameter int WIDTH     = 16,
    parameter int MAX_HOLD  = 255,
    parameter int GUARD_CYC = 2,
    localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  en,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] data_i,
    input  logic [NREQ*WIDTH-1:0] oeb_i,
    output logic [WIDTH-1:0]      gpio_out,
    output logic [WIDTH-1:0]      gpio_oeb,
    output logic [NREQ-1:0]       gnt,
    output logic [IDW-1:0]        owner_id,
    output logic                  busy,
    output logic                  preempt,
    output logic [1:0]            dbg_state,
    output logic [7:0]            dbg_hold_cnt
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GUARD = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [IDW-1:0]  last_owner;
    logic [7:0]      hold_cnt;
    logic [2:0]      guard_cnt;
    logic [IDW-1:0]  sel_id;
    logic [IDW-1:0]  cand;
    logic            sel_valid;
    logic            owner_req;
    logic            others_req;
    logic            at_max;
    logic            guard_done;

    assign owner_req  = req[owner_id];
    assign others_req = |(req & ~gnt);
    assign at_max     = (hold_cnt == 8'(MAX_HOLD));
    assign guard_done = (guard_cnt == 3'(GUARD_CYC - 1));

    // Search starts just past the previous owner so every requester gets a turn.
    always_comb begin
        sel_valid = 1'b0;
        sel_id    = '0;
        cand      = '0;
        for (int i = 1; i <= NREQ; i++) begin
            cand = IDW'((int'(last_owner) + i) % NREQ);
            if (!sel_valid && req[cand]) begin
                sel_valid = 1'b1;
                sel_id    = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (sel_valid) state_nxt = S_GRANT;
                S_GRANT: if (!owner_req || (at_max && others_req)) state_nxt = S_GUARD;
                S_GUARD: if (guard_done) state_nxt = S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state      <= S_IDLE;
            gnt        <= '0;
            owner_id   <= '0;
            last_owner <= IDW'(NREQ - 1);
            hold_cnt   <= '0;
            guard_cnt  <= '0;
            preempt    <= 1'b0;
        end else begin
            state   <= state_nxt;
            preempt <= 1'b0;
            if (!en) begin
                gnt       <= '0;
                owner_id  <= '0;
                hold_cnt  <= '0;
                guard_cnt <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (sel_valid) begin
                            gnt      <= {{(NREQ-1){1'b0}}, 1'b1} << sel_id;
                            owner_id <= sel_id;
                            hold_cnt <= '0;
                        end
                    end
                    S_GRANT: begin
                        if (state_nxt == S_GUARD) begin
                            gnt        <= '0;
                            owner_id   <= '0;
                            last_owner <= owner_id;
                            hold_cnt   <= '0;
                            guard_cnt  <= '0;
                            // A release in the same cycle wins over preemption.
                            preempt    <= owner_req;
                        end else if (!at_max) begin
                            hold_cnt <= hold_cnt + 8'd1;
                        end
                    end
                    S_GUARD: begin
                        guard_cnt <= guard_done ? 3'd0 : guard_cnt + 3'd1;
                    end
                    default: begin
                        gnt <= '0;
                    end
                endcase
            end
        end
    end

    // Pads are released unless an owner is actively granted.
    always_comb begin
        gpio_out = '0;
        gpio_oeb = '1;
        if (state == S_GRANT) begin
            for (int k = 0; k < NREQ; k++) begin
                if (owner_id == IDW'(k)) begin
                    gpio_out = data_i[k*WIDTH +: WIDTH];
                    gpio_oeb = oeb_i[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign busy         = (state != S_IDLE);
    assign dbg_state    = state;
    assign dbg_hold_cnt = hold_cnt;

endmodule

// File: tb/tb_team_05_gpio_arbiter.sv
// Bench for team_05_gpio_arbiter: reset-start vector table plus hand-written
// sequences for guard timing, preemption, saturation, enable drop and reset.
module tb_team_05_gpio_arbiter;

    logic        clk;
    logic        nrst;
    logic        en;
    logic [3:0]  req;
    logic [63:0] data_i;
    logic [63:0] oeb_i;
    logic [15:0] gpio_out;
    logic [15:0] gpio_oeb;
    logic [3:0]  gnt;
    logic [1:0]  owner_id;
    logic        busy;
    logic        preempt;
    logic [1:0]  dbg_state;
    logic [7:0]  dbg_hold_cnt;

    int checks = 0;
    int errors = 0;
    logic [3:0] exp_q[$];
    logic [3:0] prev_gnt = '0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] gnt;
        logic [1:0] owner;
    } vec_t;
    vec_t vecs[6];

    team_05_gpio_arbiter dut (
        .clk          (clk),
        .nrst         (nrst),
        .en           (en),
        .req          (req),
        .data_i       (data_i),
        .oeb_i        (oeb_i),
        .gpio_out     (gpio_out),
        .gpio_oeb     (gpio_oeb),
        .gnt          (gnt),
        .owner_id     (owner_id),
        .busy         (busy),
        .preempt      (preempt),
        .dbg_state    (dbg_state),
        .dbg_hold_cnt (dbg_hold_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Every new grant must match the next queued expectation.
    always @(negedge clk) begin
        if (gnt != 4'd0 && prev_gnt == 4'd0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL grant_unexpected: got %h expected none", gnt);
            end else begin
                check("grant", {60'd0, gnt}, {60'd0, exp_q.pop_front()});
            end
        end
        prev_gnt = gnt;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_gnt"},      {60'd0, gnt},      64'd0);
        check({tag, "_owner"},    {62'd0, owner_id}, 64'd0);
        check({tag, "_busy"},     {63'd0, busy},     64'd0);
        check({tag, "_preempt"},  {63'd0, preempt},  64'd0);
        check({tag, "_gpio_out"}, {48'd0, gpio_out}, 64'd0);
        check({tag, "_gpio_oeb"}, {48'd0, gpio_oeb}, 64'h0000_0000_0000_FFFF);
    endtask

    // Assert reset away from the clock edge, check async effect, release at a negedge.
    task automatic do_reset();
        nrst = 1'b0;
        en   = 1'b0;
        req  = 4'd0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
    endtask

    initial begin
        int bad_gnt;
        int bad_pre;

        nrst   = 1'b0;
        en     = 1'b0;
        req    = 4'd0;
        data_i = '0;
        oeb_i  = '0;

        vecs[0] = '{req: 4'b1010, gnt: 4'b0010, owner: 2'd1};
        vecs[1] = '{req: 4'b0001, gnt: 4'b0001, owner: 2'd0};
        vecs[2] = '{req: 4'b1000, gnt: 4'b1000, owner: 2'd3};
        vecs[3] = '{req: 4'b1100, gnt: 4'b0100, owner: 2'd2};
        vecs[4] = '{req: 4'b1111, gnt: 4'b0001, owner: 2'd0};
        vecs[5] = '{req: 4'b0110, gnt: 4'b0010, owner: 2'd1};

        @(negedge clk);

        // First grant after reset searches upward from requester 0.
        foreach (vecs[v]) begin
            do_reset();
            data_i = {$urandom, $urandom};
            oeb_i  = {$urandom, $urandom};
            en     = 1'b1;
            req    = vecs[v].req;
            exp_q.push_back(vecs[v].gnt);
            cyc(1);
            check("vec_owner",    {62'd0, owner_id}, {62'd0, vecs[v].owner});
            check("vec_busy",     {63'd0, busy}, 64'd1);
            check("vec_gpio_out", {48'd0, gpio_out}, {48'd0, data_i[vecs[v].owner*16 +: 16]});
            check("vec_gpio_oeb", {48'd0, gpio_oeb}, {48'd0, oeb_i[vecs[v].owner*16 +: 16]});
            data_i = {$urandom, $urandom};
            #1;
            check("vec_gpio_out_comb", {48'd0, gpio_out}, {48'd0, data_i[vecs[v].owner*16 +: 16]});
        end

        // Release with another requester waiting: guard, one idle cycle, next owner.
        do_reset();
        data_i = {$urandom, $urandom};
        oeb_i  = '0;
        en  = 1'b1;
        req = 4'b1010;
        exp_q.push_back(4'b0010);
        cyc(1);
        check("a_owner",    {62'd0, owner_id}, 64'd1);
        check("a_state",    {62'd0, dbg_state}, 64'd1);
        check("a_gpio_out", {48'd0, gpio_out}, {48'd0, data_i[31:16]});
        req = 4'b1000;
        exp_q.push_back(4'b1000);
        cyc(1);
        check("a_guard1_busy", {63'd0, busy}, 64'd1);
        check("a_guard1_gnt",  {60'd0, gnt}, 64'd0);
        check("a_guard1_oeb",  {48'd0, gpio_oeb}, 64'h0000_0000_0000_FFFF);
        check("a_guard1_pre",  {63'd0, preempt}, 64'd0);
        cyc(1);
        check("a_guard2_busy", {63'd0, busy}, 64'd1);
        check("a_guard2_oeb",  {48'd0, gpio_oeb}, 64'h0000_0000_0000_FFFF);
        cyc(1);
        check("a_idle_busy", {63'd0, busy}, 64'd0);
        check("a_idle_gnt",  {60'd0, gnt}, 64'd0);
        cyc(1);
        check("a_next_owner", {62'd0, owner_id}, 64'd3);

        // Two contenders: preemption after 256 grant cycles, then requester 1.
        do_reset();
        en  = 1'b1;
        req = 4'b0011;
        exp_q.push_back(4'b0001);
        exp_q.push_back(4'b0010);
        cyc(1);
        bad_pre = 0;
        bad_gnt = 0;
        for (int i = 0; i < 255; i++) begin
            cyc(1);
            if (preempt) bad_pre++;
            if (gnt != 4'b0001) bad_gnt++;
        end
        check("b_early_preempt", bad_pre, 64'd0);
        check("b_hold_gnt",      bad_gnt, 64'd0);
        check("b_hold_cnt",      {56'd0, dbg_hold_cnt}, 64'd255);
        cyc(1);
        check("b_preempt_pulse", {63'd0, preempt}, 64'd1);
        check("b_preempt_gnt",   {60'd0, gnt}, 64'd0);
        check("b_preempt_state", {62'd0, dbg_state}, 64'd2);
        cyc(1);
        check("b_preempt_single", {63'd0, preempt}, 64'd0);
        cyc(1);
        check("b_idle_busy", {63'd0, busy}, 64'd0);
        cyc(1);
        check("b_next_owner", {62'd0, owner_id}, 64'd1);

        // Sole requester: hold counter saturates, no preemption.
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        cyc(1);
        bad_pre = 0;
        bad_gnt = 0;
        for (int i = 0; i < 400; i++) begin
            cyc(1);
            if (preempt) bad_pre++;
            if (gnt != 4'b0100) bad_gnt++;
        end
        check("c_no_preempt", bad_pre, 64'd0);
        check("c_gnt_stable", bad_gnt, 64'd0);
        check("c_hold_sat",   {56'd0, dbg_hold_cnt}, 64'd255);

        // Enable drop during grant keeps last_owner from the earlier release.
        do_reset();
        en  = 1'b1;
        req = 4'b0010;
        exp_q.push_back(4'b0010);
        cyc(1);
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        cyc(4);
        check("d_owner2", {62'd0, owner_id}, 64'd2);
        cyc(2);
        en = 1'b0;
        cyc(1);
        check("d_en_gnt",   {60'd0, gnt}, 64'd0);
        check("d_en_oeb",   {48'd0, gpio_oeb}, 64'h0000_0000_0000_FFFF);
        check("d_en_busy",  {63'd0, busy}, 64'd0);
        check("d_en_owner", {62'd0, owner_id}, 64'd0);
        check("d_en_hold",  {56'd0, dbg_hold_cnt}, 64'd0);
        en  = 1'b1;
        req = 4'b1111;
        exp_q.push_back(4'b0100);
        cyc(1);
        check("d_rr_owner", {62'd0, owner_id}, 64'd2);

        // Reset pulse in the middle of a guard period.
        do_reset();
        en  = 1'b1;
        req = 4'b0100;
        exp_q.push_back(4'b0100);
        cyc(1);
        req = 4'b0000;
        cyc(1);
        check("e_guard_busy", {63'd0, busy}, 64'd1);
        #2;
        nrst = 1'b0;
        #1;
        check_reset_outputs("e_async");
        check("e_async_state", {62'd0, dbg_state}, 64'd0);
        req = 4'b1111;
        exp_q.push_back(4'b0001);
        @(negedge clk);
        check("e_held_gnt", {60'd0, gnt}, 64'd0);
        nrst = 1'b1;
        cyc(1);
        check("e_first_owner", {62'd0, owner_id}, 64'd0);

        cyc(1);
        check("queue_drained", exp_q.size(), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/team_05_gpio_arbiter.md
TEAM_05_GPIO_ARBITER -- requirements
Module: team_05_gpio_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the GPIO port.
REQ-002 Parameter WIDTH, default 16: number of shared GPIO pins.
REQ-003 Parameter MAX_HOLD, default 255: grant cycles before forced preemption when others are waiting; 8-bit counter.
REQ-004 Parameter GUARD_CYC, default 2: turnaround cycles between owners, range 1..7.
REQ-005 clk  input  1  system clock; all state updates on the rising edge.
REQ-006 nrst  input  1  reset; asynchronous, active-low.
REQ-007 en  input  1  chip enable; low disables arbitration and releases all pins.
REQ-008 req  input  NREQ  per-requester request level; held high while ownership is wanted.
REQ-009 data_i  input  NREQ*WIDTH  per-requester output data; slice k = bits [k*WIDTH +: WIDTH].
REQ-010 oeb_i  input  NREQ*WIDTH  per-requester active-low output enables, same slicing.
REQ-011 gpio_out  output  WIDTH  data driven to the pads.
REQ-012 gpio_oeb  output  WIDTH  active-low pad output enables.
REQ-013 gnt  output  NREQ  registered, one-hot or zero; identifies the current owner.
REQ-014 owner_id  output  $clog2(NREQ)  index of the current owner; 0 when no owner.
REQ-015 busy  output  1  high in GRANT or GUARD.
REQ-016 preempt  output  1  single-cycle pulse marking a MAX_HOLD preemption.

Function
REQ-017 FSM states SHALL be IDLE, GRANT and GUARD.
REQ-018 IDLE: with en=1 and req!=0, the block SHALL select the first set req bit searching from (last_owner+1) mod NREQ upward with wrap, load gnt and owner_id, and enter GRANT on the next edge.
REQ-019 Grant latency SHALL be exactly 1 cycle: req sampled high in IDLE at edge N gives gnt high after edge N.
REQ-020 GRANT: gpio_out SHALL equal data_i slice[owner_id] and gpio_oeb SHALL equal oeb_i slice[owner_id], combinationally from the registered owner.
REQ-021 Outside GRANT, gpio_out SHALL be all 0 and gpio_oeb SHALL be all 1.
REQ-022 GRANT: hold_cnt SHALL reset to 0 on entry, increment each cycle, and saturate at MAX_HOLD.
REQ-023 GRANT, req[owner]=0: enter GUARD, clear gnt, and set last_owner to owner.
REQ-024 GRANT, hold_cnt=MAX_HOLD with any other req bit set: enter GUARD, clear gnt, pulse preempt for 1 cycle, and set last_owner to owner.
REQ-025 GRANT, hold_cnt=MAX_HOLD with no other request: remain in GRANT with no preempt pulse.
REQ-026 If owner release and preemption occur in the same cycle, the block SHALL treat it as a release: no preempt pulse.
REQ-027 GUARD SHALL last exactly GUARD_CYC cycles, using a guard counter, then return to IDLE.
REQ-028 In GUARD, req changes SHALL be ignored; arbitration resumes in IDLE.
REQ-029 Round-robin fairness: a continuously requesting requester SHALL be granted within NREQ-1 intervening grants.
REQ-030 en=0 in any state: on the next edge, enter IDLE, clear gnt, owner_id, hold_cnt, guard counter and preempt; retain last_owner; pads are released per REQ-021.
REQ-031 busy SHALL be decoded from the registered state.

Reset
REQ-032 nrst=0 SHALL immediately force the following: state IDLE, gnt=0, owner_id=0, last_owner=NREQ-1 (so requester 0 wins first), counters 0, preempt=0, gpio_out=0, gpio_oeb all 1, busy=0.
REQ-033 Reset deassertion mid-request: the first arbitration SHALL occur on the first edge with nrst=1 and en=1.

Verification
REQ-034 Reset, then en=1, req=4'b1010 -> after 1 edge gnt=4'b0010, owner_id=1; gpio_out equals data_i[31:16].
REQ-035 Owner 1 drops req, req[3] stays high -> gpio_oeb=16'hFFFF, busy=1 for 2 cycles; IDLE for 1 cycle; then gnt=4'b1000.
REQ-036 req=4'b0011 held, MAX_HOLD=255 -> requester 0 is granted, preempt pulses after 256 GRANT cycles, and requester 1 is granted next.
REQ-037 Sole requester 2 held for 400 cycles -> gnt stays 4'b0100, preempt never pulses, and hold_cnt saturates at 255.
REQ-038 en=0 during GRANT -> next edge gnt=0, gpio_oeb=16'hFFFF, busy=0; en=1 with req=4'b1111 -> the next owner follows last_owner round-robin.
REQ-039 nrst pulsed low mid-GUARD -> all outputs reach reset values asynchronously, and requester 0 wins the first grant afterward.
